uart_tx9: RTL and testbench
===========================

UART_TX9 -- requirements
Module: uart_tx9

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-002 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port enable  input  1  permits start of a new frame.
REQ-004 SHALL have port brd  input  32  bit period in clk cycles, 24.8 fixed point (brd[31:8] integer, brd[7:0] fraction).
REQ-005 SHALL have port data_size  input  3  bits per word: 0..4 = 5,6,7,8,9 bits; 5..7 reserved, treated as 8.
REQ-006 SHALL have port parity_en  input  1  append parity bit.
REQ-007 SHALL have port parity_even  input  1  1 = even, 0 = odd parity.
REQ-008 SHALL have port stop2  input  1  1 = two stop bits, 0 = one.
REQ-009 SHALL have port fifo_data  input  9  head word of upstream TX FIFO (combinational head).
REQ-010 SHALL have port fifo_empty  input  1  upstream FIFO empty flag.
REQ-011 SHALL have port fifo_rd_request  output  1  one-cycle pop strobe to upstream FIFO.
REQ-012 SHALL have port tx  output  1  serial line, idle high.
REQ-013 SHALL have port busy  output  1  high while a frame is in progress.

Function
REQ-014 SHALL implement states IDLE, START, DATA, PARITY, STOP.
REQ-015 IDLE -> START SHALL occur when enable=1, fifo_empty=0 and brd[31:8]>=2; same edge latches fifo_data into shift register, asserts fifo_rd_request for exactly one cycle, sets busy.
REQ-016 With brd[31:8]<2 the block SHALL remain in IDLE and never pop.
REQ-017 tx SHALL be 0 in START, shift-register LSB in DATA, parity bit in PARITY, 1 in STOP and IDLE.
REQ-018 DATA SHALL send exactly data_size-selected bits LSB first; bit 8 sent only in 9-bit mode.
REQ-019 Each bit SHALL last brd[31:8] cycles, plus one extra when the 8-bit fraction accumulator (+= brd[7:0] at each bit start) carries out; accumulator SHALL clear on IDLE entry.
REQ-020 Parity SHALL be XOR of transmitted data bits only, inverted when parity_even=0; PARITY state skipped when parity_en=0.
REQ-021 STOP SHALL last one or two bit periods per stop2; then IDLE, busy low on same edge.
REQ-022 Back-to-back: if start conditions hold on STOP exit, next START SHALL follow with no idle cycle (busy stays high).
REQ-023 data_size, parity_en, parity_even, stop2, brd SHALL be sampled at frame start and held for the frame.
REQ-024 enable deasserted mid-frame SHALL complete the current frame, then idle.
REQ-025 fifo_rd_request SHALL never assert while fifo_empty=1 or outside the IDLE->START edge.

Reset
REQ-026 reset=0 SHALL immediately force: state IDLE, tx=1, busy=0, fifo_rd_request=0, shift register, bit and cycle counters, fraction accumulator to 0.
REQ-027 Reset mid-frame SHALL abort the frame; the popped word is lost, no further pop until reset released and start conditions met.

Configuration
REQ-028 Macro UART_TX9_PARITY_EN SHALL gate parity logic.
REQ-029 Defined: parity behaves per REQ-020.
REQ-030 Undefined: PARITY state, parity generator removed; parity_en, parity_even ignored; frames never carry parity.

Verification
REQ-031 brd=0x00000A00, 8N1, fifo_data=0x055 -> tx: 0,1,0,1,0,1,0,1,0,1, each 10 cycles, 100 cycles total; one fifo_rd_request pulse.
REQ-032 brd=0x00000A80, 8N1, one word -> bit periods alternate 10/11 cycles starting 10 (accumulator 0x80 then carry); frame 105 cycles.
REQ-033 9-bit mode, parity_en=1, parity_even=1, stop2=1, fifo_data=0x1FF -> start, nine 1s, parity 1, two stop bits; 13 bit periods.
REQ-034 Three words queued, enable=1 -> three contiguous frames, busy continuously high, exactly three pops, no idle gap.
REQ-035 reset asserted in DATA bit 3 -> tx=1 and busy=0 asynchronously before next clk edge; after release with fifo_empty=1, tx stays 1 and no pop.
REQ-036 brd=0x00000100 with fifo_empty=0 -> no pop, tx=1, busy=0 for 1000 cycles.

Source files
------------

// File: rtl/uart_tx9.sv
// uart_tx9: 5..9-bit UART transmitter with a 24.8 fixed-point bit-period divider.
// Parity generation is compiled in only when UART_TX9_PARITY_EN is defined.
module uart_tx9 (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [31:0] brd,
  input  logic [2:0]  data_size,
  input  logic        parity_en,
  input  logic        parity_even,
  input  logic        stop2,
  input  logic [8:0]  fifo_data,
  input  logic        fifo_empty,
  output logic        fifo_rd_request,
  output logic        tx,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t      state, state_nx;
  logic [8:0]  shreg, shreg_nx;
  logic [3:0]  bit_idx, bit_idx_nx;
  logic [23:0] cnt, cnt_nx;
  logic [7:0]  acc, acc_nx;
  logic [23:0] bint_q, bint_nx;
  logic [7:0]  bfrac_q, bfrac_nx;
  logic [3:0]  bits_m1_q, bits_m1_nx;
  logic        stop2_q, stop2_nx;
  logic        rd_req_nx;
  logic        start_ok, new_frame, new_bit;
  logic [3:0]  size_m1;
  logic [23:0] src_int;
  logic [7:0]  src_frac;
  logic [8:0]  acc_sum;

`ifdef UART_TX9_PARITY_EN
  logic        par_en_q, par_en_nx;
  logic        par_bit_q, par_bit_nx;
  logic [8:0]  data_mask;
`else
  logic        unused_parity_cfg;
  assign unused_parity_cfg = parity_en ^ parity_even;
`endif

  assign start_ok = enable && !fifo_empty && (brd[31:8] >= 24'd2);

  always_comb begin
    case (data_size)
      3'd0:    size_m1 = 4'd4;
      3'd1:    size_m1 = 4'd5;
      3'd2:    size_m1 = 4'd6;
      3'd3:    size_m1 = 4'd7;
      3'd4:    size_m1 = 4'd8;
      default: size_m1 = 4'd7;
    endcase
  end

  always_comb begin
    state_nx   = state;
    shreg_nx   = shreg;
    bit_idx_nx = bit_idx;
    cnt_nx     = cnt;
    acc_nx     = acc;
    bint_nx    = bint_q;
    bfrac_nx   = bfrac_q;
    bits_m1_nx = bits_m1_q;
    stop2_nx   = stop2_q;
    rd_req_nx  = 1'b0;
    new_frame  = 1'b0;
    new_bit    = 1'b0;
    src_int    = bint_q;
    src_frac   = bfrac_q;
    acc_sum    = '0;
`ifdef UART_TX9_PARITY_EN
    par_en_nx  = par_en_q;
    par_bit_nx = par_bit_q;
    data_mask  = '0;
`endif

    if (state == IDLE) begin
      new_frame = start_ok;
    end else if (cnt != 24'd0) begin
      cnt_nx = cnt - 24'd1;
    end else begin
      case (state)
        START: begin
          state_nx = DATA;
          new_bit  = 1'b1;
        end
        DATA: begin
          new_bit = 1'b1;
          if (bit_idx == bits_m1_q) begin
            bit_idx_nx = '0;
            state_nx   = STOP;
`ifdef UART_TX9_PARITY_EN
            if (par_en_q) state_nx = PARITY;
`endif
          end else begin
            bit_idx_nx = bit_idx + 4'd1;
            shreg_nx   = {1'b0, shreg[8:1]};
          end
        end
        PARITY: begin
          state_nx = STOP;
          new_bit  = 1'b1;
        end
        default: begin
          // STOP: bit_idx marks whether the second stop bit is already running
          if (stop2_q && bit_idx == 4'd0) begin
            bit_idx_nx = 4'd1;
            new_bit    = 1'b1;
          end else if (start_ok) begin
            new_frame = 1'b1;
          end else begin
            state_nx   = IDLE;
            bit_idx_nx = '0;
            acc_nx     = '0;
          end
        end
      endcase
    end

    if (new_frame) begin
      state_nx   = START;
      shreg_nx   = fifo_data;
      bit_idx_nx = '0;
      bint_nx    = brd[31:8];
      bfrac_nx   = brd[7:0];
      bits_m1_nx = size_m1;
      stop2_nx   = stop2;
      rd_req_nx  = 1'b1;
      new_bit    = 1'b1;
      src_int    = brd[31:8];
      src_frac   = brd[7:0];
`ifdef UART_TX9_PARITY_EN
      par_en_nx  = parity_en;
      data_mask  = ~(9'h1FF << (size_m1 + 4'd1));
      par_bit_nx = (^(fifo_data & data_mask)) ^ ~parity_even;
`endif
    end

    // Every bit start advances the fraction accumulator; its carry stretches this bit by one cycle.
    if (new_bit) begin
      acc_sum = {1'b0, acc} + {1'b0, src_frac};
      acc_nx  = acc_sum[7:0];
      cnt_nx  = src_int - 24'd1 + {23'd0, acc_sum[8]};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      shreg           <= '0;
      bit_idx         <= '0;
      cnt             <= '0;
      acc             <= '0;
      bint_q          <= '0;
      bfrac_q         <= '0;
      bits_m1_q       <= '0;
      stop2_q         <= 1'b0;
      fifo_rd_request <= 1'b0;
`ifdef UART_TX9_PARITY_EN
      par_en_q        <= 1'b0;
      par_bit_q       <= 1'b0;
`endif
    end else begin
      state           <= state_nx;
      shreg           <= shreg_nx;
      bit_idx         <= bit_idx_nx;
      cnt             <= cnt_nx;
      acc             <= acc_nx;
      bint_q          <= bint_nx;
      bfrac_q         <= bfrac_nx;
      bits_m1_q       <= bits_m1_nx;
      stop2_q         <= stop2_nx;
      fifo_rd_request <= rd_req_nx;
`ifdef UART_TX9_PARITY_EN
      par_en_q        <= par_en_nx;
      par_bit_q       <= par_bit_nx;
`endif
    end
  end

  always_comb begin
    tx = 1'b1;
    case (state)
      START:   tx = 1'b0;
      DATA:    tx = shreg[0];
`ifdef UART_TX9_PARITY_EN
      PARITY:  tx = par_bit_q;
`endif
      default: tx = 1'b1;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_tx9.sv
// Self-checking bench for uart_tx9: table vectors, corner sequences and random frames
// compared cycle by cycle against a bit-list/period model of the serial line.
module tb_uart_tx9;

`ifdef UART_TX9_PARITY_EN
  localparam bit PAR_ON = 1'b1;
`else
  localparam bit PAR_ON = 1'b0;
`endif

  typedef struct {
    logic [31:0] brd;
    logic [2:0]  ds;
    bit          pe;
    bit          pev;
    bit          st2;
    int          nw;
    logic [8:0]  w0, w1, w2;
    int          exp_len;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] brd = '0;
  logic [2:0]  data_size = '0;
  logic        parity_en = 1'b0;
  logic        parity_even = 1'b0;
  logic        stop2 = 1'b0;
  logic [8:0]  fifo_data;
  logic        fifo_empty;
  logic        fifo_rd_request;
  logic        tx;
  logic        busy;

  logic [8:0]  fmem [16];
  int          rd_ptr = 0, wr_ptr = 0;
  int          pops = 0, pop_on_empty = 0;
  int          n_vec = 0, n_bad = 0;
  int          m_acc;
  bit          exp_q[$];
  vec_t        tbl[7];

  uart_tx9 dut (
    .clk(clk), .reset(reset), .enable(enable), .brd(brd), .data_size(data_size),
    .parity_en(parity_en), .parity_even(parity_even), .stop2(stop2),
    .fifo_data(fifo_data), .fifo_empty(fifo_empty), .fifo_rd_request(fifo_rd_request),
    .tx(tx), .busy(busy)
  );

  always #5 clk = ~clk;

  assign fifo_empty = (rd_ptr >= wr_ptr);
  assign fifo_data  = fmem[rd_ptr[3:0]];

  always @(negedge clk) begin
    if (fifo_rd_request) begin
      pops++;
      if (fifo_empty) pop_on_empty++;
      else rd_ptr++;
    end
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic push(input logic [8:0] w);
    fmem[wr_ptr[3:0]] = w;
    wr_ptr++;
  endtask

  // Line model: list the bit levels of one frame, then give each its period from the 24.8 divider.
  function automatic void model_frame(input vec_t v, input logic [8:0] w);
    int nb, per;
    bit lv[$];
    bit x;
    nb = (v.ds <= 3'd4) ? int'(v.ds) + 5 : 8;
    x = 1'b0;
    lv.push_back(1'b0);
    for (int b = 0; b < nb; b++) begin
      lv.push_back(w[b]);
      x ^= w[b];
    end
    if (PAR_ON && v.pe) lv.push_back(v.pev ? x : !x);
    lv.push_back(1'b1);
    if (v.st2) lv.push_back(1'b1);
    foreach (lv[k]) begin
      m_acc += int'(v.brd[7:0]);
      per = int'(v.brd[31:8]);
      if (m_acc >= 256) begin
        per++;
        m_acc -= 256;
      end
      repeat (per) exp_q.push_back(lv[k]);
    end
  endfunction

  task automatic run_case(input vec_t v, input int drop_at, input bit scramble, input string nm);
    logic [8:0] wd[3];
    int nfr, len, bad_tx, bad_busy, busy_cnt, pops0;
    wd[0] = v.w0; wd[1] = v.w1; wd[2] = v.w2;
    nfr = (drop_at >= 0) ? 1 : v.nw;
    exp_q.delete();
    m_acc = 0;
    for (int f = 0; f < nfr; f++) model_frame(v, wd[f]);
    len = exp_q.size();
    bad_tx = -1; bad_busy = -1; busy_cnt = 0;
    @(negedge clk);
    brd = v.brd; data_size = v.ds; parity_en = v.pe; parity_even = v.pev; stop2 = v.st2;
    for (int f = 0; f < v.nw; f++) push(wd[f]);
    pops0 = pops;
    enable = 1'b1;
    for (int i = 0; i < len + 16; i++) begin
      @(negedge clk);
      if (tx !== ((i < len) ? exp_q[i] : 1'b1) && bad_tx < 0) bad_tx = i;
      if (busy !== (i < len) && bad_busy < 0) bad_busy = i;
      if (busy === 1'b1) busy_cnt++;
      if (i == drop_at) enable = 1'b0;
      if (scramble && i == 3) begin
        brd = 32'h0000_0500; data_size = 3'd0; stop2 = ~v.st2; parity_en = 1'b1;
      end
    end
    chk({nm, " tx_first_bad_cycle"}, bad_tx, -1);
    chk({nm, " busy_first_bad_cycle"}, bad_busy, -1);
    if (v.exp_len > 0) chk({nm, " busy_len"}, busy_cnt, v.exp_len);
    chk({nm, " pops"}, pops - pops0, nfr);
    enable = 1'b0;
    wr_ptr = rd_ptr;
  endtask

  initial begin
    vec_t v;
    int pops0, n0, nb;
    for (int i = 0; i < 16; i++) fmem[i] = '0;

    repeat (3) @(negedge clk);
    chk("reset tx", tx, 1);
    chk("reset busy", busy, 0);
    chk("reset rd_request", fifo_rd_request, 0);
    reset = 1'b1;
    @(negedge clk);

    //          brd           ds    pe    pev   st2   nw  w0      w1      w2      exp_len
    tbl[0] = '{32'h0000_0A00, 3'd3, 1'b0, 1'b0, 1'b0, 1, 9'h055, 9'h000, 9'h000, 100};
    tbl[1] = '{32'h0000_0A80, 3'd3, 1'b0, 1'b0, 1'b0, 1, 9'h0A5, 9'h000, 9'h000, 105};
    tbl[2] = '{32'h0000_0400, 3'd4, 1'b1, 1'b1, 1'b1, 1, 9'h1FF, 9'h000, 9'h000, PAR_ON ? 52 : 48};
    tbl[3] = '{32'h0000_0300, 3'd3, 1'b0, 1'b0, 1'b0, 3, 9'h011, 9'h1F0, 9'h07E, 90};
    tbl[4] = '{32'h0000_0240, 3'd0, 1'b1, 1'b0, 1'b0, 1, 9'h1F3, 9'h000, 9'h000, PAR_ON ? 18 : 15};
    tbl[5] = '{32'h0000_0200, 3'd6, 1'b0, 1'b0, 1'b1, 1, 9'h1AA, 9'h000, 9'h000, 22};
    tbl[6] = '{32'h0000_02FF, 3'd0, 1'b0, 1'b0, 1'b0, 1, 9'h00A, 9'h000, 9'h000, 20};
    foreach (tbl[i]) run_case(tbl[i], -1, 1'b0, $sformatf("vec%0d", i));

    // enable dropped mid-frame: current frame finishes, the queued word stays put
    v = '{32'h0000_0200, 3'd3, 1'b0, 1'b0, 1'b0, 2, 9'h0AB, 9'h154, 9'h000, 20};
    run_case(v, 5, 1'b0, "enable_drop");

    // config inputs change mid-frame: frame keeps the values sampled at its start
    v = '{32'h0000_0300, 3'd3, 1'b0, 1'b0, 1'b0, 1, 9'h0C3, 9'h000, 9'h000, 30};
    run_case(v, -1, 1'b1, "cfg_hold");

    // reset during data bit 3 of 0x0F0 (bit 3 = 0)
    @(negedge clk);
    brd = 32'h0000_0A00; data_size = 3'd3; parity_en = 1'b0; stop2 = 1'b0;
    push(9'h0F0);
    pops0 = pops;
    enable = 1'b1;
    repeat (45) @(negedge clk);
    chk("abort pre tx", tx, 0);
    #2 reset = 1'b0;
    #1;
    chk("abort async tx", tx, 1);
    chk("abort async busy", busy, 0);
    chk("abort async rd_request", fifo_rd_request, 0);
    @(negedge clk);
    reset = 1'b1;
    n0 = 0; nb = 0;
    repeat (50) begin
      @(negedge clk);
      if (tx !== 1'b1) n0++;
      if (busy !== 1'b0) nb++;
    end
    chk("abort after tx_low_cycles", n0, 0);
    chk("abort after busy_cycles", nb, 0);
    chk("abort pops", pops - pops0, 1);
    enable = 1'b0;

    // integer period below 2: never starts
    foreach (tbl[k]) begin
      if (k > 1) break;
      @(negedge clk);
      brd = (k == 0) ? 32'h0000_0100 : 32'h0000_00FF;
      push(9'h1C3);
      pops0 = pops;
      enable = 1'b1;
      n0 = 0; nb = 0;
      repeat ((k == 0) ? 1000 : 100) begin
        @(negedge clk);
        if (tx !== 1'b1) n0++;
        if (busy !== 1'b0) nb++;
      end
      chk($sformatf("slow%0d tx_low_cycles", k), n0, 0);
      chk($sformatf("slow%0d busy_cycles", k), nb, 0);
      chk($sformatf("slow%0d pops", k), pops - pops0, 0);
      enable = 1'b0;
      wr_ptr = rd_ptr;
    end

    for (int r = 0; r < 10; r++) begin
      v.brd = ($urandom_range(2, 6) << 8) | $urandom_range(0, 255);
      v.ds  = 3'($urandom_range(0, 7));
      v.pe  = 1'($urandom_range(0, 1));
      v.pev = 1'($urandom_range(0, 1));
      v.st2 = 1'($urandom_range(0, 1));
      v.nw  = $urandom_range(1, 3);
      v.w0  = 9'($urandom_range(0, 511));
      v.w1  = 9'($urandom_range(0, 511));
      v.w2  = 9'($urandom_range(0, 511));
      v.exp_len = 0;
      run_case(v, -1, 1'b0, $sformatf("rand%0d", r));
    end

    chk("pop_while_empty", pop_on_empty, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
